// File: rtl/run_controller_if.sv
// Bundles the controller's run-control inputs and the status outputs to the processor and bench.
// The controller is the slave side; the bench or top-level drives the master side.
interface run_controller_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 32
);
  logic               Start;
  logic               Mode;
  logic [CNT_W-1:0]   Stop_Count;
  logic               PC_LdEn;
  logic [INSTR_W-1:0] Instr;
  logic               CPU_Reset;
  logic               Busy;
  logic               Done;
  logic               Pass;
  logic               Timeout;
  logic [CNT_W-1:0]   Cycle_Count;
  logic [CNT_W-1:0]   Retired_Count;

  modport master (
    output Start, Mode, Stop_Count, PC_LdEn, Instr,
    input  CPU_Reset, Busy, Done, Pass, Timeout, Cycle_Count, Retired_Count
  );

  modport slave (
    input  Start, Mode, Stop_Count, PC_LdEn, Instr,
    output CPU_Reset, Busy, Done, Pass, Timeout, Cycle_Count, Retired_Count
  );
endinterface

// File: rtl/run_controller.sv
// Run controller: holds the core in reset, releases it, counts cycles and retires,
// and ends the run on halt, retire limit or watchdog. All outputs are registered.
module run_controller #(
  parameter int unsigned        INSTR_W      = 32,
  parameter int unsigned        CNT_W        = 32,
  parameter int unsigned        RESET_CYCLES = 4,
  parameter int unsigned        MAX_CYCLES   = 10000,
  parameter logic [INSTR_W-1:0] HALT_INSTR   = 32'hFFFF_FFFF
) (
  input logic             Clk,
  input logic             Reset,
  run_controller_if.slave bus
);

  localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RstW-1:0]  RstLoad  = RstW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] WdogLast = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRst, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [RstW-1:0]  r_rst_cnt, w_rst_cnt_d;
  logic             r_mode, w_mode_d;
  logic [CNT_W-1:0] r_stop, w_stop_d;
  logic [CNT_W-1:0] r_cycle, w_cycle_d;
  logic [CNT_W-1:0] r_retired, w_retired_d;
  logic             r_pass, w_pass_d;
  logic             r_timeout, w_timeout_d;
  logic             r_cpu_reset, r_busy, r_done;

  logic [CNT_W-1:0] w_cycle_inc, w_retired_inc;
  logic             w_halt, w_limit, w_wdog;

  assign w_cycle_inc   = (r_cycle == '1) ? r_cycle : r_cycle + 1'b1;
  assign w_retired_inc = (r_retired == '1) ? r_retired : r_retired + 1'b1;

  assign w_halt  = bus.PC_LdEn && (bus.Instr == HALT_INSTR);
  // Widened compare so a saturated count never aliases onto a limit, and a limit of 0 never hits.
  assign w_limit = r_mode && bus.PC_LdEn &&
                   (({1'b0, r_retired} + (CNT_W + 1)'(1)) == {1'b0, r_stop});
  assign w_wdog  = (r_cycle == WdogLast);

  always_comb begin
    w_state_d   = r_state;
    w_rst_cnt_d = r_rst_cnt;
    w_mode_d    = r_mode;
    w_stop_d    = r_stop;
    w_cycle_d   = r_cycle;
    w_retired_d = r_retired;
    w_pass_d    = r_pass;
    w_timeout_d = r_timeout;
    case (r_state)
      StIdle, StDone: begin
        if (bus.Start) begin
          w_state_d   = StRst;
          w_rst_cnt_d = RstLoad;
          w_mode_d    = bus.Mode;
          w_stop_d    = bus.Stop_Count;
          w_cycle_d   = '0;
          w_retired_d = '0;
          w_pass_d    = 1'b0;
          w_timeout_d = 1'b0;
        end
      end
      StRst: begin
        if (r_rst_cnt == '0) begin
          w_state_d = StRun;
        end else begin
          w_rst_cnt_d = r_rst_cnt - 1'b1;
        end
      end
      StRun: begin
        w_cycle_d = w_cycle_inc;
        if (bus.PC_LdEn) begin
          w_retired_d = w_retired_inc;
        end
        if (w_halt || w_limit) begin
          w_state_d = StDone;
          w_pass_d  = 1'b1;
        end else if (w_wdog) begin
          w_state_d   = StDone;
          w_timeout_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state     <= StIdle;
      r_rst_cnt   <= '0;
      r_mode      <= 1'b0;
      r_stop      <= '0;
      r_cycle     <= '0;
      r_retired   <= '0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rst_cnt   <= w_rst_cnt_d;
      r_mode      <= w_mode_d;
      r_stop      <= w_stop_d;
      r_cycle     <= w_cycle_d;
      r_retired   <= w_retired_d;
      r_pass      <= w_pass_d;
      r_timeout   <= w_timeout_d;
      r_cpu_reset <= (w_state_d != StRun);
      r_busy      <= (w_state_d == StRst) || (w_state_d == StRun);
      r_done      <= (w_state_d == StDone);
    end
  end

  assign bus.CPU_Reset     = r_cpu_reset;
  assign bus.Busy          = r_busy;
  assign bus.Done          = r_done;
  assign bus.Pass          = r_pass;
  assign bus.Timeout       = r_timeout;
  assign bus.Cycle_Count   = r_cycle;
  assign bus.Retired_Count = r_retired;

endmodule

// File: doc/run_controller.md
# run_controller

Synthesizable run controller that drives the multi-cycle processor's reset and supervises a program run. It holds the core in reset for a parametrised number of cycles, then releases it. While the core runs, it counts clock cycles and retired instructions. It ends the run on a halt instruction, on a retire-count limit, or on a watchdog timeout, and reports the outcome. It sits between the top-level clock/reset and the processor instance, and is reused by all processor benches and FPGA bring-up.

## Interface
Parameters:
- INSTR_W, 32, instruction bus width
- CNT_W, 32, width of the cycle and retire counters
- RESET_CYCLES, 4, cycles CPU_Reset is held high after Start (≥1)
- MAX_CYCLES, 10000, watchdog limit in RUN cycles (≥2, < 2^CNT_W)
- HALT_INSTR, 32'hFFFF_FFFF, instruction word that ends a run

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- Start  in  1  one-cycle pulse, begins a run from IDLE or DONE
- Mode  in  1  0 = run to halt, 1 = stop after Stop_Count retires; sampled on Start
- Stop_Count  in  CNT_W  retire limit for Mode=1; sampled on Start
- PC_LdEn  in  1  from processor; high exactly one cycle per retired instruction
- Instr  in  INSTR_W  from processor; valid when PC_LdEn=1
- CPU_Reset  out  1  active-high reset to processor
- Busy  out  1  high in RST and RUN
- Done  out  1  high in DONE
- Pass  out  1  run ended by halt or retire limit
- Timeout  out  1  run ended by watchdog
- Cycle_Count  out  CNT_W  RUN cycles elapsed
- Retired_Count  out  CNT_W  instructions retired

## Operation
- States: IDLE, RST, RUN, DONE (binary encoded, registered).
- Reset=0 (sync) → IDLE. Outputs: CPU_Reset=1, Busy=0, Done=0, Pass=0, Timeout=0, both counts 0.
- IDLE: CPU_Reset=1. On Start → RST. Start also clears the counts, Pass and Timeout, and latches Mode and Stop_Count.
- RST: CPU_Reset=1 for exactly RESET_CYCLES cycles (internal down-counter), then → RUN.
- RUN: CPU_Reset=0. Cycle_Count increments every cycle. Retired_Count increments every cycle with PC_LdEn=1.
- RUN exit conditions, in priority order, evaluated in the same cycle:
  1. PC_LdEn=1 and Instr==HALT_INSTR → DONE, Pass=1. The halt instruction is counted as retired.
  2. Mode=1 and PC_LdEn=1 and Retired_Count+1 == latched Stop_Count → DONE, Pass=1.
  3. Cycle_Count == MAX_CYCLES-1 → DONE, Timeout=1.
- Halt or limit in the same cycle as the watchdog: Pass=1, Timeout=0.
- Mode=1 with Stop_Count=0: the retire limit never matches; the run ends by halt or timeout only.
- DONE: CPU_Reset=1 (freezes the core). Counts, Pass and Timeout hold. Start → RST (new run). Start is ignored in RST and RUN.
- Counters saturate at all-ones and never wrap.
- Reset=0 in any state aborts immediately to the reset values on the next edge.

## Timing
- Start sampled at edge N → state=RST, CPU_Reset=1 from N.
- CPU_Reset falls at edge N+RESET_CYCLES. First RUN cycle has Cycle_Count=0 and shows 1 after the following edge.
- Exit: the condition is seen in cycle K. At edge K+1: Done=1, Busy=0, CPU_Reset=1, and the final counts are visible, including the terminating cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset=0 for 2 cycles, then 1, Start never pulsed → CPU_Reset=1, Busy=0, Done=0, counts 0 indefinitely.
- RESET_CYCLES=4, Start, Mode=0; PC_LdEn pulses every 5th RUN cycle; the 3rd retire has Instr=HALT_INSTR → CPU_Reset high 4 cycles; Done=1, Pass=1, Retired_Count=3, Cycle_Count=15.
- Mode=1, Stop_Count=2, no halt, PC_LdEn every 5th cycle → Done after the 2nd retire, Pass=1, Retired_Count=2, Cycle_Count=10.
- MAX_CYCLES=20, PC_LdEn never high → Done=1, Timeout=1, Pass=0, Cycle_Count=20, Retired_Count=0.
- MAX_CYCLES=20, halt retires in RUN cycle 19 (the watchdog cycle) → Pass=1, Timeout=0.
- Reset=0 mid-RUN, then Start from DONE after a completed run → immediate return to IDLE values; the restart clears the counts and repeats the 4-cycle CPU_Reset pulse.
